// File: rtl/vedic_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// vedic_seq_mult_ctrl
//
// Purpose:
//   Iterative WIDTH x WIDTH unsigned multiplier. It uses a single 4x4 Vedic
//   (Urdhva-Tiryagbhyam) core to multiply every 4-bit digit of 'a' with every
//   4-bit digit of 'b'. Each 8-bit partial product is shifted into place and
//   added into a 2*WIDTH accumulator. A whole product takes exactly N*N cycles
//   of core time, where N = WIDTH/4. Both sides use valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, sampled on the rising edge
//   in_valid   operands a/b are valid
//   in_ready   controller can accept operands (high only in IDLE)
//   a, b       WIDTH-bit unsigned multiplicand / multiplier
//   out_valid  product is valid (high only in DONE)
//   out_ready  consumer accepts the product
//   product    2*WIDTH-bit unsigned result. Only meaningful with out_valid.
//   busy       high while digit pairs are being sequenced
//
// Also contains the combinational Vedic building blocks:
//   vedic_2x2         2x2 -> 4 bit multiplier
//   Four_Bitss_vedic  4x4 -> 8 bit multiplier built from four vedic_2x2
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// vedic_2x2: 2-bit x 2-bit unsigned multiplier.
//   x, y  2-bit operands
//   p     4-bit product
// ---------------------------------------------------------------------------
module vedic_2x2 (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] p
);

   logic cross_sum;
   logic cross_carry;

   // The vertical terms give bit 0 and the upper pair. The crosswise terms
   // x1*y0 + x0*y1 give bit 1 and a carry into bit 2.
   always_comb begin
      cross_sum   = (x[1] & y[0]) ^ (x[0] & y[1]);
      cross_carry = (x[1] & y[0]) & (x[0] & y[1]);
      p[0]        = x[0] & y[0];
      p[1]        = cross_sum;
      p[2]        = (x[1] & y[1]) ^ cross_carry;
      p[3]        = (x[1] & y[1]) & cross_carry;
   end

endmodule

// ---------------------------------------------------------------------------
// Four_Bitss_vedic: 4-bit x 4-bit unsigned multiplier.
//   x, y  4-bit operands
//   p     8-bit product
// ---------------------------------------------------------------------------
module Four_Bitss_vedic (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] p
);

   logic [3:0] q_ll;
   logic [3:0] q_hl;
   logic [3:0] q_lh;
   logic [3:0] q_hh;
   logic [5:0] mid_sum;

   vedic_2x2 u_ll (.x(x[1:0]), .y(y[1:0]), .p(q_ll));
   vedic_2x2 u_hl (.x(x[3:2]), .y(y[1:0]), .p(q_hl));
   vedic_2x2 u_lh (.x(x[1:0]), .y(y[3:2]), .p(q_lh));
   vedic_2x2 u_hh (.x(x[3:2]), .y(y[3:2]), .p(q_hh));

   // The two crosswise products sit at weight 4. The upper half of the low
   // product folds into them, and what is left over above bit 3 combines
   // with the high product at weight 16. The largest result, 15*15 = 225,
   // fits in 8 bits, so the top add cannot overflow.
   always_comb begin
      mid_sum = {2'b00, q_hl} + {2'b00, q_lh} + {4'b0000, q_ll[3:2]};
      p[1:0]  = q_ll[1:0];
      p[3:2]  = mid_sum[1:0];
      p[7:4]  = q_hh + mid_sum[5:2];
   end

endmodule

// ---------------------------------------------------------------------------
// Top-level sequential controller.
// ---------------------------------------------------------------------------
module vedic_seq_mult_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int N  = WIDTH / 4;
   // Keep the index registers at least one bit wide, even when N = 1.
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   // Reject widths that do not split into whole 4-bit digits.
   generate
      if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
         $error("vedic_seq_mult_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic [2*WIDTH-1:0]   acc;
   logic [IW-1:0]        i_idx;
   logic [IW-1:0]        j_idx;

   logic [3:0]           a_digit;
   logic [3:0]           b_digit;
   logic [7:0]           core_p;
   logic [IW:0]          digit_sum;
   logic [IW+2:0]        shift_amt;
   logic [2*WIDTH-1:0]   pp_shifted;
   logic [2*WIDTH-1:0]   acc_next;

   // Pick the current digit pair from the latched operands. j walks the
   // digits of a and i walks the digits of b. Shifting right by 4*index
   // and keeping the low nibble works for any N, including N = 1.
   always_comb begin
      a_digit = 4'(a_reg >> {j_idx, 2'b00});
      b_digit = 4'(b_reg >> {i_idx, 2'b00});
   end

   Four_Bitss_vedic u_core (
      .x (a_digit),
      .y (b_digit),
      .p (core_p)
   );

   // Digit (i, j) has weight 16^(i+j). The sum is done in 2*WIDTH bits.
   // The full product always fits there, so no carry is dropped.
   always_comb begin
      digit_sum  = {1'b0, i_idx} + {1'b0, j_idx};
      shift_amt  = {digit_sum, 2'b00};
      pp_shifted = (2*WIDTH)'(core_p) << shift_amt;
      acc_next   = acc + pp_shifted;
   end

   // Control FSM. All handshake outputs are registered here, so they change
   // only on a clock edge. The product is copied from the accumulator on the
   // edge that adds the last digit pair. It then stays put until the next
   // result overwrites it, so it remains stable through any backpressure
   // and also after the handoff.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         product   <= '0;
         acc       <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= a;
                  b_reg    <= b;
                  acc      <= '0;
                  i_idx    <= '0;
                  j_idx    <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end

            BUSY: begin
               acc <= acc_next;
               if (j_idx == LAST_IDX) begin
                  j_idx <= '0;
                  if (i_idx == LAST_IDX) begin
                     i_idx     <= '0;
                     product   <= acc_next;
                     out_valid <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end else begin
                     i_idx <= i_idx + 1'b1;
                  end
               end else begin
                  j_idx <= j_idx + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vedic_seq_mult_ctrl
//
// Purpose:
//   Self-checking bench for vedic_seq_mult_ctrl. Uses one WIDTH=32 instance
//   for the main directed vectors, reset abort, backpressure and a random
//   stream, plus WIDTH=8 and WIDTH=4 instances for the small corner sizes.
//   All expected values are hand-computed constants, or a*b computed by the
//   bench for the random stream.
// ---------------------------------------------------------------------------
module tb_vedic_seq_mult_ctrl;

   logic          clk;
   logic          rst_n;

   logic          in_valid;
   logic          in_ready;
   logic [31:0]   a;
   logic [31:0]   b;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   product;
   logic          busy;

   logic          in_valid8;
   logic          in_ready8;
   logic [7:0]    a8;
   logic [7:0]    b8;
   logic          out_valid8;
   logic          out_ready8;
   logic [15:0]   product8;
   logic          busy8;

   logic          in_valid4;
   logic          in_ready4;
   logic [3:0]    a4;
   logic [3:0]    b4;
   logic          out_valid4;
   logic          out_ready4;
   logic [7:0]    product4;
   logic          busy4;

   int            compareCount;
   int            mismatchCount;
   logic [63:0]   expQ[$];

   vedic_seq_mult_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy)
   );

   vedic_seq_mult_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .product(product8), .busy(busy8)
   );

   vedic_seq_mult_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
      .product(product4), .busy(busy4)
   );

   // Free-running 10-time-unit clock. Every drive and sample happens on the
   // falling edge, well away from the rising edge the DUT uses.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one operand pair to the 32-bit DUT and returns on the falling
   // edge just after the accepting rising edge. The operands are then
   // scrambled to show that the DUT works from its own copies.
   task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("in_ready before accept", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      a        = opA;
      b        = opB;
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~opA;
      b        = opB ^ 32'hA5A5_A5A5;
   endtask

   // Counts rising edges after the accepting edge until out_valid shows up.
   task automatic waitResult(output int edges);
      edges = 0;
      while (!out_valid && edges < 200) begin
         @(negedge clk);
         edges++;
      end
   endtask

   // Full transaction with out_ready held high: checks the latency, the
   // product, the return to IDLE, and that the product is kept after handoff.
   task automatic runCase(input string tag, input logic [31:0] opA,
                          input logic [31:0] opB, input logic [63:0] expected);
      int edges;
      out_ready = 1'b1;
      applyStimulus(opA, opB);
      checkOutput({tag, " busy"}, 64'(busy), 64'd1);
      waitResult(edges);
      checkOutput({tag, " latency"}, 64'(edges), 64'd64);
      checkOutput({tag, " product"}, product, expected);
      @(negedge clk);
      checkOutput({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
      checkOutput({tag, " in_ready back"}, 64'(in_ready), 64'd1);
      checkOutput({tag, " product kept"}, product, expected);
   endtask

   initial begin
      int          edges;
      int          seen;
      int          received;
      logic [31:0] ra;
      logic [31:0] rb;

      compareCount  = 0;
      mismatchCount = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      in_valid8 = 1'b0;
      a8        = '0;
      b8        = '0;
      out_ready8 = 1'b1;
      in_valid4 = 1'b0;
      a4        = '0;
      b4        = '0;
      out_ready4 = 1'b1;

      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("reset in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset product", product, 64'd0);
      checkOutput("reset in_ready8", 64'(in_ready8), 64'd1);
      checkOutput("reset in_ready4", 64'(in_ready4), 64'd1);
      rst_n = 1'b1;

      // Directed vectors on the 32-bit instance.
      runCase("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      runCase("pow16", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
      runCase("7x9", 32'd7, 32'd9, 64'h3F);
      runCase("zero", 32'd0, 32'hDEAD_BEEF, 64'd0);
      runCase("topdigit", 32'h1000_0000, 32'h1000_0000, 64'h0100_0000_0000_0000);
      runCase("ffff", 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF);
      runCase("abcd", 32'h0000_00AB, 32'h0000_00CD, 64'h88EF);

      // Abort on the 10th BUSY edge. The previous product is nonzero, so the
      // product check below really shows the reset clearing it.
      applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort in_ready", 64'(in_ready), 64'd1);
      checkOutput("abort out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort busy", 64'(busy), 64'd0);
      checkOutput("abort product", product, 64'd0);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid || busy) seen++;
      end
      checkOutput("abort no result", 64'(seen), 64'd0);

      // Backpressure: the result must hold, and new operands must be ignored.
      out_ready = 1'b0;
      applyStimulus(32'd3, 32'd5);
      waitResult(edges);
      checkOutput("bp latency", 64'(edges), 64'd64);
      for (int k = 0; k < 20; k++) begin
         checkOutput("bp out_valid", 64'(out_valid), 64'd1);
         checkOutput("bp product", product, 64'hF);
         checkOutput("bp in_ready", 64'(in_ready), 64'd0);
         if (k == 5) begin
            in_valid = 1'b1;
            a        = 32'd2;
            b        = 32'd2;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp handoff out_valid", 64'(out_valid), 64'd0);
      checkOutput("bp handoff in_ready", 64'(in_ready), 64'd1);
      repeat (3) @(negedge clk);
      checkOutput("bp pulse ignored busy", 64'(busy), 64'd0);
      checkOutput("bp single handoff", 64'(out_valid), 64'd0);
      runCase("resubmit", 32'd2, 32'd2, 64'h4);

      // WIDTH=8 instance: N*N = 4 cycles.
      @(negedge clk);
      checkOutput("w8 in_ready", 64'(in_ready8), 64'd1);
      in_valid8 = 1'b1;
      a8        = 8'hFF;
      b8        = 8'hFF;
      @(negedge clk);
      in_valid8 = 1'b0;
      edges = 0;
      while (!out_valid8 && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      checkOutput("w8 latency", 64'(edges), 64'd4);
      checkOutput("w8 product", 64'(product8), 64'hFE01);
      @(negedge clk);
      checkOutput("w8 in_ready back", 64'(in_ready8), 64'd1);

      // WIDTH=4 instance: a single core cycle.
      checkOutput("w4 in_ready", 64'(in_ready4), 64'd1);
      in_valid4 = 1'b1;
      a4        = 4'hF;
      b4        = 4'hF;
      @(negedge clk);
      in_valid4 = 1'b0;
      edges = 0;
      while (!out_valid4 && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      checkOutput("w4 latency", 64'(edges), 64'd1);
      checkOutput("w4 product", 64'(product4), 64'hE1);
      @(negedge clk);
      checkOutput("w4 in_ready back", 64'(in_ready4), 64'd1);

      // Random stream with gaps on both sides, checked in order against a*b.
      received = 0;
      fork
         begin
            for (int n = 0; n < 100; n++) begin
               int guard;
               ra = $urandom;
               rb = $urandom;
               if (n % 10 == 0) ra = 32'hFFFF_FFFF;
               if (n % 13 == 0) rb = 32'd0;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               in_valid = 1'b1;
               a        = ra;
               b        = rb;
               guard    = 0;
               while (!in_ready && guard < 1000) begin
                  @(negedge clk);
                  guard++;
               end
               checkOutput("stream accept", 64'(in_ready), 64'd1);
               expQ.push_back(64'(ra) * 64'(rb));
               @(negedge clk);
               in_valid = 1'b0;
            end
         end
         begin
            int cyc;
            cyc = 0;
            while (received < 100 && cyc < 20000) begin
               @(negedge clk);
               cyc++;
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  if (expQ.size() == 0) begin
                     checkOutput("stream unexpected", 64'(out_valid), 64'd0);
                  end else begin
                     checkOutput("stream product", product, expQ.pop_front());
                  end
                  received++;
               end
            end
            out_ready = 1'b1;
         end
      join
      checkOutput("stream count", 64'(received), 64'd100);
      checkOutput("stream leftovers", 64'(expQ.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
